// File: rtl/fifo_rd_stream.sv
// Read-side adapter: turns a FIFO rd_en/empty port with 1-cycle read latency into a
// first-word-fall-through valid/ready stream with frame tagging via out_last.
module fifo_rd_stream #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              clr,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int unsigned BeatW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BeatW-1:0] BeatMax = BeatW'(FRAME_LEN - 1);

  logic [1:0]        occ_q, occ_d;
  logic              inflight_q;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic              pop;
  logic [2:0]        credit;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf0_q;
  assign out_last  = out_valid & (beat_q == BeatMax);
  assign pop       = out_valid & out_ready;

  // Words that will sit in the buffer after this cycle, counting the one in flight.
  // occ_q >= 1 whenever pop is set, so this never underflows.
  assign credit     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = ~rest & ~clr & ~fifo_empty & (credit < 3'd2);

  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    beat_d = beat_q;

    if (pop) begin
      beat_d = (beat_q == BeatMax) ? '0 : beat_q + BeatW'(1);
    end

    case ({inflight_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = fifo_rd_data;
        end else begin
          buf1_d = fifo_rd_data;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Head leaves while a new word lands; occupancy is unchanged.
        if (occ_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = fifo_rd_data;
        end else begin
          buf0_d = fifo_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      beat_q     <= '0;
    end else if (clr) begin
      // Drops buffered words and any word returning from a read issued last cycle.
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      beat_q     <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO array model plus an in-order scoreboard of delivered words,
// frame position, stall stability and buffer occupancy.
module tb_fifo_rd_stream;

  localparam int unsigned FrameLen = 16;

  logic       clk;
  logic       rest;
  logic       clr;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  fifo_rd_stream #(
    .DATA_W   (8),
    .FRAME_LEN(FrameLen)
  ) dut (
    .clk         (clk),
    .rest        (rest),
    .clr         (clr),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  // FIFO model: word storage, write pointer from stimulus, read pointer from accepted reads.
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or posedge rest) begin
    if (rest) begin
      rd_ptr       <= 0;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end else begin
      fifo_rd_data <= 8'($urandom);
    end
  end

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Reference state: index of the next word owed downstream and its position in the frame.
  int exp_idx = 0;
  int beat = 0;
  int n_pop = 0;
  int n_last = 0;
  logic [7:0] last_word = '0;
  logic       held = 1'b0;
  logic [7:0] hold_data = '0;
  logic       hold_last = 1'b0;
  logic       grab = 1'b0;
  logic [7:0] first_pop = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  // One clock: judge the cycle at the falling edge, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (held) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hold_data);
      chk("hold_last", out_last, hold_last);
    end
    chk("occupancy_le2", (rd_ptr - exp_idx) <= 2, 1);
    if (fifo_empty) chk("rd_en_when_empty", fifo_rd_en, 0);
    if (clr) begin
      chk("clr_rd_en", fifo_rd_en, 0);
      exp_idx = rd_ptr;
      beat    = 0;
    end else if (out_valid && out_ready) begin
      chk("sb_data", out_data, mem[exp_idx]);
      chk("sb_last", out_last, beat == FrameLen - 1);
      if (out_last) begin
        n_last++;
        last_word = out_data;
      end
      if (grab) begin
        first_pop = out_data;
        grab      = 1'b0;
      end
      exp_idx++;
      beat = (beat + 1) % FrameLen;
      n_pop++;
    end
    held      = out_valid && !out_ready && !clr;
    hold_data = out_data;
    hold_last = out_last;
    @(posedge clk);
    #1;
  endtask

  int p0;
  int l0;
  int r0;

  initial begin
    clk       = 1'b0;
    rest      = 1'b1;
    clr       = 1'b0;
    out_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
    end
    rest = 1'b0;
    step();
    step();
    chk("idle_valid", out_valid, 0);

    // Single word: read at t, visible at t+2, gone at t+3.
    out_ready = 1'b1;
    push(8'hA5);
    #1;
    chk("single_rd_en", fifo_rd_en, 1);
    step();
    chk("single_t1_valid", out_valid, 0);
    step();
    chk("single_t2_valid", out_valid, 1);
    chk("single_t2_data", out_data, 8'hA5);
    step();
    chk("single_t3_valid", out_valid, 0);

    // Realign the frame counter, then stream 20 words at full rate.
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 20; i++) push(8'(i));
    p0 = n_pop;
    l0 = n_last;
    for (int i = 1; i <= 22; i++) begin
      step();
      if (i == 1) chk("stream_lat1_valid", out_valid, 0);
      if (i == 2) begin
        chk("stream_lat2_valid", out_valid, 1);
        chk("stream_first_data", out_data, 0);
      end
    end
    chk("stream_pops", n_pop - p0, 20);
    chk("stream_last_count", n_last - l0, 1);
    chk("stream_last_word", last_word, 15);

    // Backpressure: only two reads may be issued while stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(8'(100 + i));
    r0 = rd_ptr;
    for (int i = 0; i < 8; i++) step();
    chk("bp_reads", rd_ptr - r0, 2);
    chk("bp_rd_en", fifo_rd_en, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 100);
    out_ready = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 8; i++) step();
    chk("bp_pops_no_gap", n_pop - p0, 8);
    for (int i = 0; i < 6; i++) step();
    chk("bp_drained", exp_idx, wr_ptr);

    // Alternating ready over 32 random words.
    for (int i = 0; i < 32; i++) push(8'($urandom));
    p0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      out_ready = (i % 2) == 0;
      step();
    end
    chk("alt_pops", n_pop - p0, 32);
    chk("alt_drained", exp_idx, wr_ptr);

    // clr with one word buffered and one in flight: both vanish, 204 comes next.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(8'(200 + i));
    p0 = n_pop;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    clr       = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_valid", out_valid, 0);
    chk("clr_last", out_last, 0);
    grab      = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("clr_first_after", first_pop, 204);
    chk("clr_total_pops", n_pop - p0, 8);
    chk("clr_drained", exp_idx, wr_ptr);

    // Random traffic, ready and occasional clr.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(1, 0) == 1) push(8'($urandom));
      out_ready = $urandom_range(1, 0) == 1;
      clr       = $urandom_range(15, 0) == 0;
      step();
    end
    clr       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("rand_drained", exp_idx, wr_ptr);
    chk("rand_idle_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
